// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and defaults for the data memory controller (DATA_MEM_PARITY_EN adds a parity bit)
package data_mem_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int AW_DEFAULT = 8;

`ifdef DATA_MEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - request/response bus between a memory client and data_mem_ctrl
interface data_mem_if #(
    parameter int DW = 8,
    parameter int AW = 8
) ();

    logic [AW-1:0] DataAddress;
    logic          ReadMem;
    logic          WriteMem;
    logic [DW-1:0] DataIn;
    logic          ClearReq;
    logic [DW-1:0] DataOut;
    logic          DataValid;
    logic          Busy;
    logic          ParityErr;

    modport master (
        output DataAddress, ReadMem, WriteMem, DataIn, ClearReq,
        input  DataOut, DataValid, Busy, ParityErr
    );

    modport slave (
        input  DataAddress, ReadMem, WriteMem, DataIn, ClearReq,
        output DataOut, DataValid, Busy, ParityErr
    );

endinterface

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - storage core: one write port, one registered read port
module data_mem_array #(
    parameter int W  = 8,
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register samples the pre-write word, giving read-before-write on a shared address;
    // it only loads on a read, so the last result is held in between.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - clear-sweep FSM, request gating and read outputs (DATA_MEM_PARITY_EN adds parity check)
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic        CLK,
    input  logic        reset,
    data_mem_if.slave   bus
);

    localparam int W = DW + PAR_W;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          valid_q;
    logic          rd_acc;
    logic          wr_acc;
    logic          arr_we;
    logic [AW-1:0] arr_waddr;
    logic [W-1:0]  arr_wdata;
    logic [W-1:0]  arr_rdata;
    logic [W-1:0]  wr_word;

`ifdef DATA_MEM_PARITY_EN
    assign wr_word = {^bus.DataIn, bus.DataIn};
`else
    assign wr_word = bus.DataIn;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            valid_q   <= rd_acc;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        // A clear request claims the cycle, so a same-cycle access is dropped.
        rd_acc    = (state_q == IDLE) && !bus.ClearReq && !reset && bus.ReadMem;
        wr_acc    = (state_q == IDLE) && !bus.ClearReq && !reset && bus.WriteMem;
        arr_we    = 1'b0;
        arr_waddr = bus.DataAddress;
        arr_wdata = wr_word;
        case (state_q)
            IDLE: begin
                arr_we = wr_acc;
                if (bus.ClearReq && !reset) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                arr_we    = !reset;
                arr_waddr = clr_ptr_q;
                arr_wdata = '0;
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == {AW{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    data_mem_array #(
        .W  (W),
        .AW (AW)
    ) u_array (
        .CLK   (CLK),
        .reset (reset),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (rd_acc),
        .raddr (bus.DataAddress),
        .rdata (arr_rdata)
    );

    assign bus.DataOut   = arr_rdata[DW-1:0];
    assign bus.DataValid = valid_q;
    assign bus.Busy      = (state_q == CLEAR);

`ifdef DATA_MEM_PARITY_EN
    // Even parity over data plus stored bit is nonzero exactly on a mismatch.
    assign bus.ParityErr = valid_q & (^arr_rdata);
`else
    assign bus.ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl (parity case under DATA_MEM_PARITY_EN)
module tb_data_mem_ctrl;

    logic CLK;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    data_mem_if #(.DW(8), .AW(8)) bus ();

    data_mem_ctrl #(.DW(8), .AW(8)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    always @(negedge CLK) begin
        if (bus.DataValid === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_valid cyc=%0d DataOut=%h", cyc, bus.DataOut);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.DataOut !== e.data || bus.ParityErr !== e.perr || cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL read_data got data=%h perr=%b cyc=%0d want data=%h perr=%b cyc=%0d",
                             bus.DataOut, bus.ParityErr, cyc, e.data, e.perr, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.DataAddress = a;
        bus.DataIn      = d;
        bus.WriteMem    = 1'b1;
        tick();
        bus.WriteMem    = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] d, input logic pe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        bus.DataAddress = a;
        bus.ReadMem     = 1'b1;
        tick();
        bus.ReadMem     = 1'b0;
    endtask

    task automatic rw(input logic [7:0] a, input logic [7:0] d, input logic [7:0] old);
        exp_t e;
        e.data = old;
        e.perr = 1'b0;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        bus.DataAddress = a;
        bus.DataIn      = d;
        bus.ReadMem     = 1'b1;
        bus.WriteMem    = 1'b1;
        tick();
        bus.ReadMem     = 1'b0;
        bus.WriteMem    = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.Busy === 1'b1 && n < 1000) begin
            n = n + 1;
            tick();
        end
    endtask

    initial begin
        int n;
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.DataAddress = '0;
        bus.DataIn      = '0;
        bus.ReadMem     = 1'b0;
        bus.WriteMem    = 1'b0;
        bus.ClearReq    = 1'b0;

        tick();
        reset = 1'b0;
        chk("reset_busy", 32'(bus.Busy), 32'd1);
        chk("reset_dataout", 32'(bus.DataOut), 32'h00);
        chk("reset_valid", 32'(bus.DataValid), 32'd0);
        chk("reset_perr", 32'(bus.ParityErr), 32'd0);
        count_busy(n);
        chk("reset_sweep_len", 32'(n), 32'd256);

        rd(8'h00, 8'h00, 1'b0);
        rd(8'h7F, 8'h00, 1'b0);
        rd(8'hFF, 8'h00, 1'b0);
        tick();

        wr(8'h10, 8'hA5);
        rd(8'h10, 8'hA5, 1'b0);
        chk("valid_after_read", 32'(bus.DataValid), 32'd1);
        tick();
        chk("hold_valid_low", 32'(bus.DataValid), 32'd0);
        chk("hold_dataout", 32'(bus.DataOut), 32'hA5);

        wr(8'h20, 8'h11);
        rw(8'h20, 8'h22, 8'h11);
        rd(8'h20, 8'h22, 1'b0);

        wr(8'hFF, 8'h5A);
        wr(8'h00, 8'h3C);
        rd(8'hFF, 8'h5A, 1'b0);
        rd(8'h00, 8'h3C, 1'b0);
        wr(8'h05, 8'h77);
        rd(8'h05, 8'h77, 1'b0);
        tick();

        bus.ClearReq    = 1'b1;
        bus.WriteMem    = 1'b1;
        bus.DataAddress = 8'h05;
        bus.DataIn      = 8'h33;
        tick();
        bus.ClearReq    = 1'b0;
        bus.WriteMem    = 1'b0;
        n = 0;
        while (bus.Busy === 1'b1 && n < 1000) begin
            bus.ReadMem  = (n < 5);
            bus.WriteMem = (n == 3);
            bus.ClearReq = (n == 10);
            n = n + 1;
            tick();
        end
        bus.ReadMem  = 1'b0;
        bus.WriteMem = 1'b0;
        bus.ClearReq = 1'b0;
        chk("clear_sweep_len", 32'(n), 32'd256);
        rd(8'h05, 8'h00, 1'b0);
        rd(8'h10, 8'h00, 1'b0);
        rd(8'hFF, 8'h00, 1'b0);
        tick();

        bus.ClearReq = 1'b1;
        tick();
        bus.ClearReq = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("busy_mid_sweep", 32'(bus.Busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n);
        chk("reset_mid_sweep_len", 32'(n), 32'd256);

`ifdef DATA_MEM_PARITY_EN
        wr(8'h40, 8'h07);
        wr(8'h41, 8'h03);
        dut.u_array.mem[64][8] = ~dut.u_array.mem[64][8];
        rd(8'h40, 8'h07, 1'b1);
        rd(8'h41, 8'h03, 1'b0);
        tick();
`endif

        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on posedge CLK only.
REQ-002 Parameter DW, default 8: data word width in bits.
REQ-003 Parameter AW, default 8: address width; DEPTH = 2**AW words.
REQ-004 CLK  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset; starts a clear sweep.
REQ-006 DataAddress  in  AW  word address for read or write.
REQ-007 ReadMem  in  1  read request, sampled on CLK.
REQ-008 WriteMem  in  1  write request, sampled on CLK.
REQ-009 DataIn  in  DW  write data.
REQ-010 ClearReq  in  1  single-cycle request to zero the whole array.
REQ-011 DataOut  out  DW  registered read data, held between reads.
REQ-012 DataValid  out  1  one-cycle pulse: DataOut carries fresh read data.
REQ-013 Busy  out  1  high while clearing; accesses are dropped.
REQ-014 ParityErr  out  1  registered parity mismatch flag, qualified by DataValid.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and CLEAR.
REQ-016 In CLEAR, each cycle SHALL write zero (and correct parity) to core[ClrPtr] and increment ClrPtr; after writing DEPTH-1, the state SHALL go to IDLE with ClrPtr = 0.
REQ-017 Busy SHALL equal (state == CLEAR), so a sweep holds Busy high for exactly DEPTH cycles.
REQ-018 In IDLE, ClearReq SHALL move to CLEAR next cycle; a ReadMem/WriteMem in that same cycle SHALL be dropped.
REQ-019 ClearReq during CLEAR SHALL be ignored; the sweep does not restart.
REQ-020 ReadMem/WriteMem while Busy SHALL be dropped silently: no write, no DataValid.
REQ-021 A read accepted in cycle N SHALL drive DataOut = core[DataAddress] and DataValid = 1 in cycle N+1 (1-cycle latency).
REQ-022 A write accepted in cycle N SHALL update core[DataAddress] at the edge ending cycle N.
REQ-023 ReadMem and WriteMem together at one address SHALL return the old word (read-before-write) and store DataIn.
REQ-024 A read at address A in cycle N+1 after a write to A in cycle N SHALL return the new data.
REQ-025 DataOut SHALL hold its last value when DataValid = 0; it SHALL never be tristated.
REQ-026 Addresses SHALL cover 0..DEPTH-1 with no wrap logic; ClrPtr SHALL count in AW bits.

Reset
REQ-027 reset SHALL force state = CLEAR, ClrPtr = 0, DataOut = 0, DataValid = 0, ParityErr = 0; Busy reads 1 in the first cycle after reset.
REQ-028 reset asserted mid-sweep SHALL restart the sweep at ClrPtr = 0.
REQ-029 reset SHALL take priority over ClearReq, ReadMem and WriteMem.

Configuration
REQ-030 Macro DATA_MEM_PARITY_EN defined: each word SHALL store an extra even-parity bit (^DataIn) on write; on read, ParityErr SHALL be registered as the recomputed parity XOR the stored bit, in the same cycle as DataValid.
REQ-031 Macro undefined: no parity storage SHALL exist, and ParityErr SHALL be tied to 0.

Structure
REQ-032 Package data_mem_pkg SHALL hold the state enum typedef (IDLE, CLEAR) and the default DW/AW constants.
REQ-033 Storage SHALL sit in sub-module data_mem_array: one write port, one synchronous read port, width DW (+1 with parity).
REQ-034 The FSM, ClrPtr, request gating and output registers SHALL live in data_mem_ctrl.

Verification (DW=8, AW=8)
REQ-035 Reset for 1 cycle, then idle -> Busy = 1 for exactly 256 cycles; read of addresses 0, 127 and 255 afterwards returns 0.
REQ-036 Write 0xA5 to 0x10, then read 0x10 next cycle -> DataOut = 0xA5 and DataValid = 1 exactly one cycle after the read.
REQ-037 With core[0x20] = 0x11, ReadMem and WriteMem of 0x22 to 0x20 in the same cycle -> DataOut = 0x11; the next read returns 0x22.
REQ-038 ClearReq with a same-cycle write of 0x33 to 0x05 -> write dropped, 256-cycle sweep runs, read of 0x05 returns 0; reads during Busy give no DataValid.
REQ-039 reset asserted at sweep cycle 100 -> Busy stays high for 256 further cycles.
REQ-040 DATA_MEM_PARITY_EN defined: force a stored parity bit flip at 0x40 holding 0x07, read 0x40 -> ParityErr = 1 with DataValid; a clean word gives ParityErr = 0.
